// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory fetch responder with fixed latency and load port
// One outstanding fetch; misaligned/out-of-range addresses return NOP_WORD with err set.

module imem_responder #(
    parameter int          DEPTH_LOG2 = 8,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic                  imem_clock_in,
    input  logic                  imem_reset_in,
    input  logic                  fetch_req_in,
    input  logic [31:0]           fetch_addr_in,
    output logic                  fetch_ready_out,
    output logic                  fetch_valid_out,
    output logic [31:0]           fetch_data_out,
    output logic                  fetch_err_out,
    input  logic                  load_we_in,
    input  logic [DEPTH_LOG2-1:0] load_addr_in,
    input  logic [31:0]           load_data_in
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(LATENCY + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         counter;
    logic [31:0]           addr_q;
    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic                  enter_resp;
    logic [31:0]           rd_addr;
    logic [DEPTH_LOG2-1:0] rd_index;
    logic                  rd_err;

    assign fetch_ready_out = (state == ST_IDLE);
    assign fetch_valid_out = (state == ST_RESP);
    assign accept          = fetch_ready_out && fetch_req_in;

    // With LATENCY==1 the read happens on the accept edge, so the live address is used.
    always_comb begin
        rd_addr    = (state == ST_IDLE) ? fetch_addr_in : addr_q;
        rd_index   = rd_addr[DEPTH_LOG2+1:2];
        rd_err     = (|rd_addr[1:0]) | (|rd_addr[31:DEPTH_LOG2+2]);
        enter_resp = (accept && (LATENCY == 1)) ||
                     ((state == ST_WAIT) && (counter == CW'(1)));
    end

    always_ff @(posedge imem_clock_in) begin
        if (imem_reset_in) begin
            state          <= ST_IDLE;
            counter        <= '0;
            addr_q         <= '0;
            fetch_data_out <= '0;
            fetch_err_out  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q  <= fetch_addr_in;
                        counter <= CW'(LATENCY - 1);
                        state   <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (counter == CW'(1)) begin
                        state <= ST_RESP;
                    end else begin
                        counter <= counter - CW'(1);
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // Nonblocking read of mem gives read-before-write against a same-edge load.
            if (enter_resp) begin
                fetch_data_out <= rd_err ? NOP_WORD : mem[rd_index];
                fetch_err_out  <= rd_err;
            end
        end
    end

    always_ff @(posedge imem_clock_in) begin
        if (!imem_reset_in && load_we_in) begin
            mem[load_addr_in] <= load_data_in;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed self-checking bench for imem_responder (LATENCY 2 and 1)

module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;

    logic        ready2, valid2, err2;
    logic [31:0] data2;
    logic        ready1, valid1, err1;
    logic [31:0] data1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_LOG2(8), .LATENCY(2), .NOP_WORD(32'h00000013)) u_lat2 (
        .imem_clock_in  (clk),
        .imem_reset_in  (rst),
        .fetch_req_in   (req),
        .fetch_addr_in  (addr),
        .fetch_ready_out(ready2),
        .fetch_valid_out(valid2),
        .fetch_data_out (data2),
        .fetch_err_out  (err2),
        .load_we_in     (we),
        .load_addr_in   (waddr),
        .load_data_in   (wdata)
    );

    imem_responder #(.DEPTH_LOG2(8), .LATENCY(1), .NOP_WORD(32'h00000013)) u_lat1 (
        .imem_clock_in  (clk),
        .imem_reset_in  (rst),
        .fetch_req_in   (req),
        .fetch_addr_in  (addr),
        .fetch_ready_out(ready1),
        .fetch_valid_out(valid1),
        .fetch_data_out (data1),
        .fetch_err_out  (err1),
        .load_we_in     (we),
        .load_addr_in   (waddr),
        .load_data_in   (wdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Single fetch on the LATENCY=2 instance with cycle-exact ready/valid checks.
    task automatic fetch2(input string name, input logic [31:0] a,
                          input logic [31:0] exp_data, input logic exp_err);
        @(negedge clk);
        check({name, " ready_before"}, 32'(ready2), 32'd1);
        req = 1'b1; addr = a;
        @(negedge clk);
        req = 1'b0; addr = 32'hFFFF_FFFF;
        check({name, " ready_wait"}, 32'(ready2), 32'd0);
        check({name, " valid_wait"}, 32'(valid2), 32'd0);
        @(negedge clk);
        check({name, " valid_resp"}, 32'(valid2), 32'd1);
        check({name, " ready_resp"}, 32'(ready2), 32'd0);
        check({name, " data"}, data2, exp_data);
        check({name, " err"}, 32'(err2), 32'(exp_err));
        @(negedge clk);
        check({name, " ready_after"}, 32'(ready2), 32'd1);
        check({name, " valid_after"}, 32'(valid2), 32'd0);
        check({name, " data_hold"}, data2, exp_data);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; waddr = '0; wdata = '0;
        vecs[0] = '{32'h00000000, 32'h00500093, 1'b0};
        vecs[1] = '{32'h00000002, 32'h00000013, 1'b1};
        vecs[2] = '{32'h00000400, 32'h00000013, 1'b1};
        vecs[3] = '{32'h000003FC, 32'hCAFEF00D, 1'b0};
        vecs[4] = '{32'h00000001, 32'h00000013, 1'b1};
        vecs[5] = '{32'h00000008, 32'h12345678, 1'b0};
        vecs[6] = '{32'h80000000, 32'h00000013, 1'b1};
        vecs[7] = '{32'h00000403, 32'h00000013, 1'b1};
        vecs[8] = '{32'h00000004, 32'h00100113, 1'b0};

        repeat (3) @(negedge clk);
        check("reset ready", 32'(ready2), 32'd1);
        check("reset valid", 32'(valid2), 32'd0);
        check("reset data", data2, 32'd0);
        check("reset err", 32'(err2), 32'd0);
        rst = 1'b0;

        load(8'd0, 32'h00500093);
        load(8'd1, 32'h00100113);
        load(8'd2, 32'h12345678);
        load(8'd255, 32'hCAFEF00D);

        for (int i = 0; i < 9; i++) begin
            fetch2($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_data, vecs[i].exp_err);
        end

        // Held request: LATENCY=2 pulses every 3rd cycle, LATENCY=1 every 2nd.
        @(negedge clk);
        req = 1'b1; addr = 32'h00000004;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("thru2 valid c%0d", i), 32'(valid2), 32'((i % 3) == 1));
            check($sformatf("thru1 valid c%0d", i), 32'(valid1), 32'((i % 2) == 0));
            if ((i % 3) == 1) check($sformatf("thru2 data c%0d", i), data2, 32'h00100113);
            if ((i % 2) == 0) check($sformatf("thru1 data c%0d", i), data1, 32'h00100113);
        end
        req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during WAIT aborts the fetch; a load attempted during reset is dropped.
        req = 1'b1; addr = 32'h00000000;
        @(negedge clk);
        req = 1'b0;
        check("abort in_wait", 32'(ready2), 32'd0);
        rst = 1'b1; we = 1'b1; waddr = 8'd2; wdata = 32'h0BADBAD0;
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        check("abort valid", 32'(valid2), 32'd0);
        check("abort ready", 32'(ready2), 32'd1);
        check("abort data", data2, 32'd0);
        check("abort err", 32'(err2), 32'd0);
        @(negedge clk);
        check("abort no_pulse", 32'(valid2), 32'd0);
        fetch2("after_reset mem0", 32'h00000000, 32'h00500093, 1'b0);
        fetch2("reset_blocks_load", 32'h00000008, 32'h12345678, 1'b0);

        // Load on the edge entering RESP: old word returned, new word on next fetch.
        @(negedge clk);
        req = 1'b1; addr = 32'h00000004;
        @(negedge clk);
        req = 1'b0;
        we = 1'b1; waddr = 8'd1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        we = 1'b0;
        check("rbw valid", 32'(valid2), 32'd1);
        check("rbw data", data2, 32'h00100113);
        @(negedge clk);
        fetch2("rbw new", 32'h00000004, 32'hDEADBEEF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
